cpu_branch_resolver: RTL and testbench
======================================

Name: cpu_branch_resolver

Overview:
Consumer side of the fetch-stage next-PC prediction. Fetch pushes every predicted next PC into an in-order queue; execute pops the oldest entry and supplies the actual next PC. A mismatch raises a one-cycle registered redirect to the correct PC and flushes all younger (wrong-path) predictions. Sits between the fetch PC logic and the execute/branch unit of the pipelined core.

Parameters:
QUEUE_DEPTH, 4, number of in-flight predictions; power of two, 2..16
CNT_W, $clog2(QUEUE_DEPTH)+1, occupancy counter width (derived, do not override)

Ports:
i_clk  input  1  core clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_push_valid  input  1  fetch issues an instruction with a prediction this cycle
i_push_pred_pc  input  32  predicted next PC of that instruction
o_push_ready  output  1  queue accepts a push this cycle
i_resolve_valid  input  1  execute resolves the oldest in-flight instruction
i_actual_pc  input  32  actual next PC computed in execute
o_redirect  output  1  registered one-cycle pulse: mispredict, fetch must restart
o_redirect_pc  output  32  correct PC, valid while o_redirect=1
o_count  output  CNT_W  current queue occupancy
o_resolve_err  output  1  registered one-cycle pulse: resolve with empty queue
o_resolved_cnt  output  32  resolved-instruction counter (optional feature)
o_mispredict_cnt  output  32  misprediction counter (optional feature)

Behaviour:
- Reset (async on i_rst_n low): state RUN, read/write pointers 0, o_count=0, o_redirect=0, o_redirect_pc=0, o_resolve_err=0, counters 0.
- Storage: circular buffer, QUEUE_DEPTH x 32, pointers wrap modulo QUEUE_DEPTH; full/empty from o_count.
- State machine: RUN, REDIRECT.
- RUN:
  - o_push_ready = (o_count != QUEUE_DEPTH). Full blocks push even if a resolve pops the same cycle.
  - Push accepted when i_push_valid && o_push_ready: write at wptr, wptr++, count++.
  - Resolve with count>0: compare head entry with i_actual_pc (full 32-bit equality).
    - Match: rptr++, count-- (net 0 with a simultaneous accepted push).
    - Mismatch: whole queue flushed next edge (pointers 0, count 0; any same-cycle push discarded); o_redirect=1, o_redirect_pc=i_actual_pc next cycle; go to REDIRECT.
  - Resolve with count=0: ignored, o_resolve_err=1 for one cycle; no bypass of a same-cycle push (push still accepted).
- REDIRECT (exactly one cycle): o_redirect=1; o_push_ready=0; pushes and resolves ignored (no error pulse); next state RUN with o_redirect=0.
- Latency: mismatch to o_redirect = 1 cycle (registered). Back-to-back mispredicts impossible; minimum 2 cycles between redirect pulses.
- o_redirect_pc holds its last value when o_redirect=0.
- Reset mid-operation (including during REDIRECT): immediate return to reset values, queue contents discarded.

Optional Feature:
Macro BRANCH_RESOLVER_STATS_EN.
- Defined: o_resolved_cnt increments on every resolve accepted in RUN with count>0 (match or mismatch); o_mispredict_cnt increments on every mismatch. Both 32-bit, wrap at 2^32, reset to 0.
- Not defined: counter logic absent; both ports tied to 0. Ports always present.

Test Plan:
- Push 0x100,0x104; resolve with 0x100 then 0x104 -> no o_redirect, o_count 2->1->0, o_resolve_err stays 0.
- Push 4 entries (depth 4) -> o_push_ready=0 with o_count=4; 5th push plus simultaneous matching resolve -> push rejected, o_count=3.
- Push 0x200,0x204,0x208; resolve oldest with 0x300 -> next cycle o_redirect=1, o_redirect_pc=0x300, o_count=0; push during that cycle ignored; following cycle o_redirect=0, o_push_ready=1.
- Resolve with empty queue while pushing 0x400 -> o_resolve_err pulses one cycle, o_count=1, no redirect.
- Wrap: 10 push/resolve pairs with matching PCs across depth 4 -> no redirect, o_count returns to 0; with BRANCH_RESOLVER_STATS_EN, o_resolved_cnt=10, o_mispredict_cnt=0; without it both 0.
- Assert i_rst_n low asynchronously during REDIRECT -> o_redirect=0, o_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_branch_resolver_if.sv
// Fetch/execute-facing bundle of cpu_branch_resolver: prediction push, resolve and redirect.
// Signal names keep the block's original port names so existing connections map one-to-one.
interface cpu_branch_resolver_if #(
    parameter int unsigned QUEUE_DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1
);
    logic             i_push_valid;
    logic [31:0]      i_push_pred_pc;
    logic             o_push_ready;
    logic             i_resolve_valid;
    logic [31:0]      i_actual_pc;
    logic             o_redirect;
    logic [31:0]      o_redirect_pc;
    logic [CNT_W-1:0] o_count;
    logic             o_resolve_err;
    logic [31:0]      o_resolved_cnt;
    logic [31:0]      o_mispredict_cnt;

    // Pipeline side: drives pushes/resolves, observes redirect and status.
    modport master (
        output i_push_valid, i_push_pred_pc, i_resolve_valid, i_actual_pc,
        input  o_push_ready, o_redirect, o_redirect_pc, o_count, o_resolve_err,
               o_resolved_cnt, o_mispredict_cnt
    );

    modport slave (
        input  i_push_valid, i_push_pred_pc, i_resolve_valid, i_actual_pc,
        output o_push_ready, o_redirect, o_redirect_pc, o_count, o_resolve_err,
               o_resolved_cnt, o_mispredict_cnt
    );
endinterface

// File: rtl/cpu_branch_resolver.sv
// In-order queue of predicted next PCs checked against execute; mismatch flushes and redirects.
// Optional resolve/mispredict statistics counters enabled by macro BRANCH_RESOLVER_STATS_EN.
module cpu_branch_resolver #(
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    cpu_branch_resolver_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);

    typedef enum logic {
        RUN,
        REDIRECT
    } state_t;

    state_t           state_q;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      mem_q [QUEUE_DEPTH];
    logic             redirect_q;
    logic [31:0]      redirect_pc_q;
    logic             err_q;

    logic             push_ready;
    logic             push_fire;
    logic             pop_valid;
    logic             mismatch;
    logic             match;
    logic             empty_resolve;

    always_comb begin
        push_ready    = (state_q == RUN) && (count_q != CNT_W'(QUEUE_DEPTH));
        push_fire     = bus.i_push_valid && push_ready;
        pop_valid     = (state_q == RUN) && bus.i_resolve_valid && (count_q != '0);
        mismatch      = pop_valid && (mem_q[rptr_q] != bus.i_actual_pc);
        match         = pop_valid && !mismatch;
        empty_resolve = (state_q == RUN) && bus.i_resolve_valid && (count_q == '0);
    end

    // Contents need no reset: pointers and count define which entries are live.
    always_ff @(posedge i_clk) begin
        if (push_fire) begin
            mem_q[wptr_q] <= bus.i_push_pred_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= RUN;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    redirect_q <= 1'b0;
                    err_q      <= empty_resolve;
                    if (mismatch) begin
                        // Flush everything, including a push landing this same cycle.
                        wptr_q        <= '0;
                        rptr_q        <= '0;
                        count_q       <= '0;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= bus.i_actual_pc;
                        state_q       <= REDIRECT;
                    end else begin
                        if (push_fire) begin
                            wptr_q <= wptr_q + PTR_W'(1);
                        end
                        if (match) begin
                            rptr_q <= rptr_q + PTR_W'(1);
                        end
                        count_q <= count_q + CNT_W'(push_fire) - CNT_W'(match);
                    end
                end
                REDIRECT: begin
                    redirect_q <= 1'b0;
                    err_q      <= 1'b0;
                    state_q    <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] resolved_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            resolved_cnt_q   <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (pop_valid) begin
                resolved_cnt_q <= resolved_cnt_q + 32'd1;
            end
            if (mismatch) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign bus.o_resolved_cnt   = resolved_cnt_q;
    assign bus.o_mispredict_cnt = mispredict_cnt_q;
`else
    assign bus.o_resolved_cnt   = '0;
    assign bus.o_mispredict_cnt = '0;
`endif

    assign bus.o_push_ready  = push_ready;
    assign bus.o_redirect    = redirect_q;
    assign bus.o_redirect_pc = redirect_pc_q;
    assign bus.o_count       = count_q;
    assign bus.o_resolve_err = err_q;
endmodule

// File: tb/tb_cpu_branch_resolver.sv
// Directed self-checking bench for cpu_branch_resolver (depth 4), expected values hand-derived.
// Stats expectations follow BRANCH_RESOLVER_STATS_EN when the bench is built with it.
module tb_cpu_branch_resolver;
    logic clk;
    logic rst_n;
    int unsigned vectors;
    int unsigned miscompares;

    cpu_branch_resolver_if #(.QUEUE_DEPTH(4)) bus ();

    cpu_branch_resolver #(.QUEUE_DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic rv, input logic [31:0] apc);
        bus.i_push_valid    = pv;
        bus.i_push_pred_pc  = ppc;
        bus.i_resolve_valid = rv;
        bus.i_actual_pc     = apc;
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] res, input logic [31:0] mis);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk({tag, "_resolved"}, bus.o_resolved_cnt, res);
        chk({tag, "_mispred"}, bus.o_mispredict_cnt, mis);
`else
        chk({tag, "_resolved"}, bus.o_resolved_cnt, 32'h0);
        chk({tag, "_mispred"}, bus.o_mispredict_cnt, 32'h0);
        if (res == 32'hFFFF_FFFF && mis == 32'hFFFF_FFFF) $display("unreachable");
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);

        // Reset state
        #12;
        chk("rst_redirect", {31'b0, bus.o_redirect}, 32'h0);
        chk("rst_count", {29'b0, bus.o_count}, 32'h0);
        chk("rst_err", {31'b0, bus.o_resolve_err}, 32'h0);
        chk("rst_redirect_pc", bus.o_redirect_pc, 32'h0);
        chk("rst_push_ready", {31'b0, bus.o_push_ready}, 32'h1);
        chk_stats("rst", 32'd0, 32'd0);
        rst_n = 1'b1;
        tick();

        // Two matching resolves
        drive(1'b1, 32'h100, 1'b0, 32'h0); tick();
        chk("t1_count_a", {29'b0, bus.o_count}, 32'd1);
        drive(1'b1, 32'h104, 1'b0, 32'h0); tick();
        chk("t1_count_b", {29'b0, bus.o_count}, 32'd2);
        drive(1'b0, 32'h0, 1'b1, 32'h100); tick();
        chk("t1_count_c", {29'b0, bus.o_count}, 32'd1);
        chk("t1_redirect_c", {31'b0, bus.o_redirect}, 32'h0);
        chk("t1_err_c", {31'b0, bus.o_resolve_err}, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'h104); tick();
        chk("t1_count_d", {29'b0, bus.o_count}, 32'd0);
        chk("t1_redirect_d", {31'b0, bus.o_redirect}, 32'h0);
        chk("t1_err_d", {31'b0, bus.o_resolve_err}, 32'h0);

        // Full queue blocks a push even with a simultaneous pop
        drive(1'b1, 32'h10, 1'b0, 32'h0); tick();
        drive(1'b1, 32'h14, 1'b0, 32'h0); tick();
        drive(1'b1, 32'h18, 1'b0, 32'h0); tick();
        drive(1'b1, 32'h1C, 1'b0, 32'h0); tick();
        chk("t2_full_count", {29'b0, bus.o_count}, 32'd4);
        chk("t2_full_ready", {31'b0, bus.o_push_ready}, 32'h0);
        drive(1'b1, 32'h20, 1'b1, 32'h10); tick();
        chk("t2_count_after", {29'b0, bus.o_count}, 32'd3);
        chk("t2_redirect", {31'b0, bus.o_redirect}, 32'h0);
        chk("t2_ready_after", {31'b0, bus.o_push_ready}, 32'h1);
        drive(1'b0, 32'h0, 1'b1, 32'h14); tick();
        drive(1'b0, 32'h0, 1'b1, 32'h18); tick();
        drive(1'b0, 32'h0, 1'b1, 32'h1C); tick();
        chk("t2_drained", {29'b0, bus.o_count}, 32'd0);
        chk("t2_no_redirect", {31'b0, bus.o_redirect}, 32'h0);

        // Mispredict: flush and one-cycle redirect
        drive(1'b1, 32'h200, 1'b0, 32'h0); tick();
        drive(1'b1, 32'h204, 1'b0, 32'h0); tick();
        drive(1'b1, 32'h208, 1'b0, 32'h0); tick();
        chk("t3_count", {29'b0, bus.o_count}, 32'd3);
        drive(1'b0, 32'h0, 1'b1, 32'h300); tick();
        chk("t3_redirect", {31'b0, bus.o_redirect}, 32'h1);
        chk("t3_redirect_pc", bus.o_redirect_pc, 32'h300);
        chk("t3_flush_count", {29'b0, bus.o_count}, 32'd0);
        chk("t3_ready_redir", {31'b0, bus.o_push_ready}, 32'h0);
        drive(1'b1, 32'h500, 1'b1, 32'h500); tick();
        chk("t3_redirect_end", {31'b0, bus.o_redirect}, 32'h0);
        chk("t3_count_ignored", {29'b0, bus.o_count}, 32'd0);
        chk("t3_no_err", {31'b0, bus.o_resolve_err}, 32'h0);
        chk("t3_ready_back", {31'b0, bus.o_push_ready}, 32'h1);
        chk("t3_pc_hold", bus.o_redirect_pc, 32'h300);

        // Resolve on empty queue with a simultaneous push
        drive(1'b1, 32'h400, 1'b1, 32'h400); tick();
        chk("t4_err", {31'b0, bus.o_resolve_err}, 32'h1);
        chk("t4_count", {29'b0, bus.o_count}, 32'd1);
        chk("t4_redirect", {31'b0, bus.o_redirect}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0); tick();
        chk("t4_err_pulse", {31'b0, bus.o_resolve_err}, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'h400); tick();
        chk("t4_drain", {29'b0, bus.o_count}, 32'd0);
        chk("t4_drain_redirect", {31'b0, bus.o_redirect}, 32'h0);
        chk_stats("t4", 32'd8, 32'd1);

        // Fresh reset, then 10 overlapped push/resolve pairs wrapping the pointers
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk_stats("t5_rst", 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h1000 + 32'(i) * 4, i > 0, 32'h1000 + 32'(i - 1) * 4);
            tick();
            chk("t5_occupancy", {29'b0, bus.o_count}, 32'd1);
            chk("t5_redirect", {31'b0, bus.o_redirect}, 32'h0);
        end
        drive(1'b0, 32'h0, 1'b1, 32'h1024); tick();
        chk("t5_final_count", {29'b0, bus.o_count}, 32'd0);
        chk("t5_final_redirect", {31'b0, bus.o_redirect}, 32'h0);
        chk_stats("t5", 32'd10, 32'd0);

        // Asynchronous reset while in REDIRECT
        drive(1'b1, 32'h600, 1'b0, 32'h0); tick();
        drive(1'b0, 32'h0, 1'b1, 32'h604); tick();
        chk("t6_redirect", {31'b0, bus.o_redirect}, 32'h1);
        chk("t6_redirect_pc", bus.o_redirect_pc, 32'h604);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_redirect", {31'b0, bus.o_redirect}, 32'h0);
        chk("t6_async_count", {29'b0, bus.o_count}, 32'd0);
        chk("t6_async_pc", bus.o_redirect_pc, 32'h0);
        chk("t6_async_ready", {31'b0, bus.o_push_ready}, 32'h1);
        chk_stats("t6", 32'd0, 32'd0);
        #2 rst_n = 1'b1;
        drive(1'b1, 32'h700, 1'b0, 32'h0); tick();
        chk("t6_post_count", {29'b0, bus.o_count}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 32'h0); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
